// File: rtl/display_defs_pkg.sv
`default_nettype none
// ============================================================================
// Module      : display_defs
// Description : Shared 7-segment display constants and the hex7 glyph table.
// Revision    : 1.0 - initial release
// ============================================================================
package display_defs;

   localparam logic [7:0] AN_IDLE    = 8'hFF;
   localparam logic [7:0] SEG_BLANK  = 8'hFF;
   localparam int         NUM_DIGITS = 8;

   // Active-low gfedcba glyphs for one hex nibble.
   function automatic logic [6:0] hex7(input logic [3:0] nib);
      logic [6:0] seg;
      seg = 7'h7F;
      case (nib)
         4'h0: seg = 7'h40;
         4'h1: seg = 7'h79;
         4'h2: seg = 7'h24;
         4'h3: seg = 7'h30;
         4'h4: seg = 7'h19;
         4'h5: seg = 7'h12;
         4'h6: seg = 7'h02;
         4'h7: seg = 7'h78;
         4'h8: seg = 7'h00;
         4'h9: seg = 7'h10;
         4'hA: seg = 7'h08;
         4'hB: seg = 7'h03;
         4'hC: seg = 7'h46;
         4'hD: seg = 7'h21;
         4'hE: seg = 7'h06;
         4'hF: seg = 7'h0E;
         default: seg = 7'h7F;
      endcase
      return seg;
   endfunction

endpackage
`default_nettype wire

// File: rtl/seg_hex_decode.sv
`default_nettype none
// ============================================================================
// Module      : seg_hex_decode
// Description : Combinational hex nibble to active-low gfedcba segments.
// Revision    : 1.0 - initial release
// ============================================================================
module seg_hex_decode
   import display_defs::*;
(
   input  logic [3:0] nib,
   output logic [6:0] seg
);

   assign seg = hex7(nib);

endmodule
`default_nettype wire

// File: rtl/seg_scan_driver.sv
`default_nettype none
// ============================================================================
// Module      : seg_scan_driver
// Description : 8-digit common-anode 7-segment scan driver with per-frame
//               snapshot, leading-zero blanking, decimal points and freeze.
// Revision    : 1.0 - initial release
// ============================================================================
module seg_scan_driver
   import display_defs::*;
#(
   parameter int SCAN_DIV = 100000,
   parameter int CNT_W    = 17
)(
   input  logic        clk,
   input  logic        rst_n,
   input  logic [31:0] value,
   input  logic [7:0]  dp_mask,
   input  logic        lz_blank,
   input  logic        freeze,
   output logic [7:0]  AN,
   output logic [7:0]  SEG,
   output logic        frame_done
);

   localparam logic [CNT_W-1:0] C_LAST = CNT_W'(SCAN_DIV - 1);

   logic [CNT_W-1:0] r_prescaler;
   logic [2:0]       r_digit_idx;
   logic [31:0]      r_shadow_val;
   logic [7:0]       r_shadow_dp;
   logic             r_load_pend;

   logic             w_tick;
   logic             w_wrap;
   logic             w_load;
   logic [4:0]       w_bit_ofs;
   logic [3:0]       w_nib;
   logic [31:0]      w_upper;
   logic             w_blank;
   logic [6:0]       w_seg;

   assign w_tick    = (r_prescaler == C_LAST);
   assign w_wrap    = w_tick && (r_digit_idx == 3'd7);
   assign w_load    = (w_wrap || r_load_pend) && !freeze;
   assign w_bit_ofs = {r_digit_idx, 2'b00};
   assign w_nib     = r_shadow_val[w_bit_ofs +: 4];

   // Digit is blanked when it and every more-significant nibble are zero.
   assign w_upper = r_shadow_val >> w_bit_ofs;
   assign w_blank = lz_blank && (r_digit_idx != 3'd0) && (w_upper == 32'd0);

   seg_hex_decode u_hex_decode (
      .nib (w_nib),
      .seg (w_seg)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_prescaler  <= '0;
         r_digit_idx  <= 3'd0;
         r_shadow_val <= 32'd0;
         r_shadow_dp  <= 8'd0;
         r_load_pend  <= 1'b1;
         AN           <= AN_IDLE;
         SEG          <= SEG_BLANK;
         frame_done   <= 1'b0;
      end else begin
         r_prescaler <= w_tick ? '0 : r_prescaler + 1'b1;
         if (w_tick) begin
            r_digit_idx <= r_digit_idx + 3'd1;
         end
         if (w_load) begin
            r_shadow_val <= value;
            r_shadow_dp  <= dp_mask;
            r_load_pend  <= 1'b0;
         end
         AN         <= ~(8'b1 << r_digit_idx);
         SEG        <= w_blank ? SEG_BLANK : {~r_shadow_dp[r_digit_idx], w_seg};
         frame_done <= w_wrap;
      end
   end

endmodule
`default_nettype wire
